// File: rtl/prog_counter_irq.sv
// Programmable run counter with start/done interrupts and periodic auto-reload.
// Every output comes straight from a flop; the next value of each flop is built in one combinational block.
module prog_counter_irq #(
    parameter int WIDTH        = 16,
    parameter int DEFAULT_STOP = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] stop_val,
    input  logic             auto_reload,
    input  logic             ack,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             irqStart,
    output logic             irqDone,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DEF_STOP = WIDTH'(DEFAULT_STOP);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    state_t           state_r, state_s;
    logic [WIDTH-1:0] count_r, count_s;
    logic [WIDTH-1:0] stop_r, stop_s;
    logic             mode_r, mode_s;
    logic             busy_r, busy_s;
    logic             irq_start_r, irq_start_s;
    logic             irq_done_r, irq_done_s;
    logic             overrun_r, overrun_s;
    logic             tc_s;
    logic             irq_done_base_s;
    logic             overrun_base_s;

    // Next-state and next-output logic; abort outranks terminal count, which outranks ack.
    always_comb begin
        state_s         = state_r;
        count_s         = count_r;
        stop_s          = stop_r;
        mode_s          = mode_r;
        irq_start_s     = 1'b0;
        irq_done_base_s = ack ? 1'b0 : irq_done_r;
        overrun_base_s  = ack ? 1'b0 : overrun_r;
        irq_done_s      = irq_done_base_s;
        overrun_s       = overrun_base_s;
        tc_s            = (state_r == RUN) && (count_r == (stop_r - ONE));

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s     = RUN;
                    count_s     = ZERO;
                    stop_s      = (stop_val == ZERO) ? DEF_STOP : stop_val;
                    mode_s      = auto_reload;
                    irq_start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_s    = IDLE;
                    count_s    = ZERO;
                    irq_done_s = 1'b0;
                    overrun_s  = 1'b0;
                end else if (tc_s) begin
                    irq_done_s = 1'b1;
                    if (mode_r) begin
                        count_s   = ZERO;
                        // an event still pending that is not being acknowledged right now is lost
                        overrun_s = (irq_done_r && !ack) ? 1'b1 : overrun_base_s;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    count_s = count_r + ONE;
                end
            end
            DONE: begin
                if (abort) begin
                    state_s    = IDLE;
                    count_s    = ZERO;
                    irq_done_s = 1'b0;
                    overrun_s  = 1'b0;
                end else if (ack) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s    = IDLE;
                count_s    = ZERO;
                irq_done_s = 1'b0;
                overrun_s  = 1'b0;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            count_r     <= ZERO;
            stop_r      <= DEF_STOP;
            mode_r      <= 1'b0;
            busy_r      <= 1'b0;
            irq_start_r <= 1'b0;
            irq_done_r  <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            stop_r      <= stop_s;
            mode_r      <= mode_s;
            busy_r      <= busy_s;
            irq_start_r <= irq_start_s;
            irq_done_r  <= irq_done_s;
            overrun_r   <= overrun_s;
        end
    end

    assign count    = count_r;
    assign busy     = busy_r;
    assign irqStart = irq_start_r;
    assign irqDone  = irq_done_r;
    assign overrun  = overrun_r;

endmodule

// File: tb/tb_prog_counter_irq.sv
// Directed bench for prog_counter_irq: inputs change and outputs are sampled on the falling edge.
// Output vector layout: {count[15:0], busy, irqStart, irqDone, overrun}.
module tb_prog_counter_irq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] stop_val;
    logic        auto_reload;
    logic        ack;
    logic        abort;
    logic [15:0] count;
    logic        busy;
    logic        irqStart;
    logic        irqDone;
    logic        overrun;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [19:0] obs;
    logic [19:0] exp_v;

    assign obs = {count, busy, irqStart, irqDone, overrun};

    prog_counter_irq #(.WIDTH(16), .DEFAULT_STOP(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop_val   (stop_val),
        .auto_reload(auto_reload),
        .ack        (ack),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .irqStart   (irqStart),
        .irqDone    (irqDone),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; stop_val = 16'd3; auto_reload = 1'b1; ack = 1'b0; abort = 1'b0;
        step(); step();
        exp_v = {16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL reset: got %h expected %h", obs, exp_v);
        else pass_cnt++;
        start = 1'b0; auto_reload = 1'b0; rst_n = 1'b1;
        step();
    endtask

    task automatic test_one_shot();
        start = 1'b1; stop_val = 16'd5; auto_reload = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            step();
            start = 1'b0;
            if (c <= 5) exp_v = {16'(c - 1), 1'b1, (c == 1), 1'b0, 1'b0};
            else        exp_v = {16'd4, 1'b1, 1'b0, 1'b1, 1'b0};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL one_shot c%0d: got %h expected %h", c, obs, exp_v);
            else pass_cnt++;
        end
        ack = 1'b1; step(); ack = 1'b0;
        exp_v = {16'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL one_shot_ack: got %h expected %h", obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_periodic();
        start = 1'b1; stop_val = 16'd3; auto_reload = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            start = 1'b0;
            exp_v = {16'(i % 3), 1'b1, (i == 0), (i >= 3), (i >= 6)};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL periodic c%0d: got %h expected %h", i + 1, obs, exp_v);
            else pass_cnt++;
        end
        // ack in the same cycle as a terminal count: the new event survives, overrun clears
        ack = 1'b1; step();
        exp_v = {16'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL periodic_ack_tc: got %h expected %h", obs, exp_v);
        else pass_cnt++;
        step(); ack = 1'b0;
        exp_v = {16'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL periodic_ack: got %h expected %h", obs, exp_v);
        else pass_cnt++;
        abort = 1'b1; step(); abort = 1'b0;
        exp_v = {16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL periodic_abort: got %h expected %h", obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_zero_stop();
        start = 1'b1; stop_val = 16'd0; auto_reload = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            step();
            start = 1'b0;
            if (c <= 10) exp_v = {16'(c - 1), 1'b1, (c == 1), 1'b0, 1'b0};
            else         exp_v = {16'd9, 1'b1, 1'b0, 1'b1, 1'b0};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL zero_stop c%0d: got %h expected %h", c, obs, exp_v);
            else pass_cnt++;
        end
        ack = 1'b1; step(); ack = 1'b0;
    endtask

    task automatic test_stop_one();
        start = 1'b1; stop_val = 16'd1; auto_reload = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            step();
            start = 1'b0;
            exp_v = {16'd0, 1'b1, (c == 1), (c == 2), 1'b0};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL stop_one c%0d: got %h expected %h", c, obs, exp_v);
            else pass_cnt++;
        end
        ack = 1'b1; step(); ack = 1'b0;
    endtask

    task automatic test_abort();
        start = 1'b1; stop_val = 16'd8; auto_reload = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            start = 1'b0;
        end
        abort = 1'b1; step(); abort = 1'b0;
        exp_v = {16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL abort_mid: got %h expected %h", obs, exp_v);
        else pass_cnt++;
        // abort on the terminal-count cycle of a two-count run
        start = 1'b1; stop_val = 16'd2;
        step(); start = 1'b0;
        step();
        abort = 1'b1; step(); abort = 1'b0;
        step();
        exp_v = {16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL abort_tc: got %h expected %h", obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_ignored_start();
        start = 1'b1; stop_val = 16'd4; auto_reload = 1'b0;
        step(); start = 1'b0;
        start = 1'b1; stop_val = 16'd7; auto_reload = 1'b1;
        step(); start = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            step();
            if (c <= 4) exp_v = {16'(c - 1), 1'b1, 1'b0, 1'b0, 1'b0};
            else        exp_v = {16'd3, 1'b1, 1'b0, 1'b1, 1'b0};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL ignored_start c%0d: got %h expected %h", c, obs, exp_v);
            else pass_cnt++;
        end
        start = 1'b1; ack = 1'b1; stop_val = 16'd5;
        step(); start = 1'b0; ack = 1'b0;
        step();
        exp_v = {16'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL start_with_ack: got %h expected %h", obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        start = 1'b1; stop_val = 16'd8; auto_reload = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            start = 1'b0;
        end
        rst_n = 1'b0; step(); rst_n = 1'b1;
        exp_v = {16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL reset_midrun: got %h expected %h", obs, exp_v);
        else pass_cnt++;
        start = 1'b1; stop_val = 16'd2;
        for (int c = 1; c <= 3; c++) begin
            step();
            start = 1'b0;
            if (c <= 2) exp_v = {16'(c - 1), 1'b1, (c == 1), 1'b0, 1'b0};
            else        exp_v = {16'd1, 1'b1, 1'b0, 1'b1, 1'b0};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL after_reset c%0d: got %h expected %h", c, obs, exp_v);
            else pass_cnt++;
        end
        ack = 1'b1; step(); ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_zero_stop();
        test_stop_one();
        test_abort();
        test_ignored_start();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
